io_port_unit: RTL and testbench
===============================

Name: io_port_unit

Overview:
- Peripheral-side counterpart of the processor's I/O interface.
- Buffers externally supplied words into a small FIFO and presents the head word to the core's input port for IN instructions.
- Latches words written by OUT instructions onto an external output port.
- Raises the core's interrupt line when input data is waiting, and runs an assert/acknowledge/done handshake with the core.

Parameters:
- DATA_W, 16, width of input/output data words.
- IN_DEPTH, 4, input FIFO depth in words; power of two, minimum 2.
- CNT_W, $clog2(IN_DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ext_in_data  input  DATA_W  word from external source.
- ext_in_valid  input  1  external word present this cycle.
- ext_in_ready  output  1  FIFO can accept (not full).
- cpu_in_data  output  DATA_W  FIFO head word, driven to the core input port; 0 when empty.
- cpu_in_rd  input  1  core consumes the head word (IN executed).
- cpu_out_wr  input  1  core executes OUT.
- cpu_out_data  input  DATA_W  core output value.
- out_port  output  DATA_W  registered external output port.
- out_strobe  output  1  one-cycle pulse the cycle out_port changes.
- irq_en  input  1  interrupt generation enable.
- irq  output  1  interrupt request to the core.
- irq_ack  input  1  core has taken the interrupt.
- irq_done  input  1  core executed RTI.
- in_count  output  CNT_W  FIFO occupancy.
- in_ovf  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (async, all outputs immediately):
  - out_port=0, out_strobe=0, irq=0, in_count=0, in_ovf=0, ext_in_ready=1, cpu_in_data=0.
  - FIFO pointers cleared; IRQ FSM returns to IRQ_IDLE.
  - Reset mid-handshake or mid-transfer discards all buffered data and any in-flight push/pop.
- FIFO push: on the clk edge where ext_in_valid && ext_in_ready. The word appears on cpu_in_data the next cycle if the FIFO was empty.
- FIFO pop: on the clk edge where cpu_in_rd && in_count!=0. A pop when empty is ignored.
- cpu_in_data: combinational read of the head entry.
- ext_in_ready = (in_count != IN_DEPTH).
  - A push is refused when full, even if a pop occurs in the same cycle.
  - Push and pop together when not full: count unchanged, data order preserved.
- Pointers wrap modulo IN_DEPTH. in_count saturates at IN_DEPTH and never underflows.
- Output path: on a clk edge with cpu_out_wr, out_port <= cpu_out_data and out_strobe=1 for exactly that following cycle.
  - Back-to-back writes give a strobe every cycle.
  - Without a write, out_port holds its value.
- IRQ FSM, irq registered:
  - IRQ_IDLE: irq=0. Go to IRQ_REQ when irq_en && in_count!=0.
  - IRQ_REQ: irq=1. Go to IRQ_SERVICE on irq_ack.
    - If irq_en drops before the ack, return to IRQ_IDLE.
    - If the FIFO empties before the ack, stay in IRQ_REQ until the ack (no retraction).
  - IRQ_SERVICE: irq=0, interrupt is in service. Go to IRQ_IDLE on irq_done.
    - irq_ack in this state is ignored.
    - If the FIFO is still non-empty, IRQ_IDLE re-requests on the next cycle, giving a minimum 1-cycle irq low gap.
  - irq_ack and irq_done together in IRQ_REQ: treated as ack only.
  - irq_ack or irq_done in IRQ_IDLE: ignored.

Optional Feature:
- IO_IN_OVERFLOW_EN defined:
  - in_ovf is set when ext_in_valid is high while the FIFO is full (word dropped).
  - in_ovf is sticky and cleared only by rst or by a pop that occurs in a cycle without a new overflow.
- Undefined: in_ovf is tied to 0, the port is retained, and dropped words go unrecorded.

Decomposition:
- Shared package io_pkg:
  - irq_state_t enum {IRQ_IDLE, IRQ_REQ, IRQ_SERVICE}.
  - Default DATA_W/IN_DEPTH constants.
- Sub-module io_fifo: parameterised synchronous FIFO with async reset, exposing push/pop/head/count/full/empty.
- io_port_unit instantiates io_fifo and holds the output register and the IRQ FSM.

Test Plan:
- Reset then idle → out_port=0, irq=0, in_count=0, ext_in_ready=1, cpu_in_data=0.
- Push 0x1111, 0x2222, 0x3333, 0x4444 (depth 4) → in_count=4, ext_in_ready=0. A 5th push of 0x5555 is dropped, and in_ovf=1 if IO_IN_OVERFLOW_EN. Four pops return 0x1111..0x4444 in order, and a further pop leaves in_count=0.
- cpu_out_wr with 0xBEEF, then 0x0001 on consecutive cycles → out_port=0xBEEF then 0x0001, with out_strobe high for two cycles.
- irq_en=1, push 0x00AA → irq rises 1 cycle after in_count becomes 1. irq_ack → irq=0. Pop, then irq_done → FSM in IRQ_IDLE, irq stays 0.
- Same as above but push two words and pop only one before irq_done → irq re-asserts exactly one cycle after returning to IRQ_IDLE.
- Assert rst while in IRQ_SERVICE with in_count=3 → irq=0 and in_count=0 immediately; after release a push of 0x0F0F is the head word.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: definitions shared by the I/O port unit and its input FIFO.
//   irq_state_t  : states of the interrupt handshake FSM
//   DEF_DATA_W   : default data word width
//   DEF_IN_DEPTH : default input FIFO depth (power of two, >= 2)
package io_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_IN_DEPTH = 4;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst          clock / async reset (clears pointers and count)
//   push, push_data   write request; refused when full, even if popping
//   pop               read request; ignored when empty
//   head              current head entry, 0 when empty (combinational)
//   count             occupancy, 0..DEPTH
//   full, empty       occupancy flags
module io_fifo
    import io_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_IN_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) wide, so +1 wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: peripheral side of the core's I/O interface.
//   - buffers external words in an input FIFO; the head word drives the
//     core's input port and is consumed by cpu_in_rd
//   - latches OUT data onto out_port with a one-cycle out_strobe
//   - raises irq while input data waits, with ack / done handshake
// Ports:
//   clk, rst                          clock / async active-high reset
//   ext_in_data/valid/ready           external input stream
//   cpu_in_data, cpu_in_rd            core input port and consume strobe
//   cpu_out_wr, cpu_out_data          core OUT write
//   out_port, out_strobe              registered external output
//   irq_en, irq, irq_ack, irq_done    interrupt handshake
//   in_count                          FIFO occupancy
//   in_ovf                            sticky drop flag
// Configuration: define IO_IN_OVERFLOW_EN to record dropped input words
// in in_ovf; otherwise in_ovf is tied to 0.
module io_port_unit
    import io_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IN_DEPTH = DEF_IN_DEPTH,
    parameter int CNT_W    = $clog2(IN_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] cpu_in_data,
    input  logic              cpu_in_rd,
    input  logic              cpu_out_wr,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic [DATA_W-1:0] out_port,
    output logic              out_strobe,
    input  logic              irq_en,
    output logic              irq,
    input  logic              irq_ack,
    input  logic              irq_done,
    output logic [CNT_W-1:0]  in_count,
    output logic              in_ovf
);

    logic fifo_full, fifo_empty;

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ext_in_valid),
        .push_data (ext_in_data),
        .pop       (cpu_in_rd),
        .head      (cpu_in_data),
        .count     (in_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ext_in_ready = !fifo_full;

    // ---------------- output register ----------------
    logic [DATA_W-1:0] out_port_q, out_port_d;
    logic              out_strobe_q, out_strobe_d;

    always_comb begin
        out_port_d   = cpu_out_wr ? cpu_out_data : out_port_q;
        out_strobe_d = cpu_out_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_port_q   <= '0;
            out_strobe_q <= 1'b0;
        end else begin
            out_port_q   <= out_port_d;
            out_strobe_q <= out_strobe_d;
        end
    end

    assign out_port   = out_port_q;
    assign out_strobe = out_strobe_q;

    // ---------------- overflow flag ----------------
`ifdef IO_IN_OVERFLOW_EN
    logic in_ovf_q, in_ovf_d;
    logic ovf_evt, pop_ok;

    // A push into a full FIFO is dropped even if a pop happens alongside.
    assign ovf_evt = ext_in_valid && fifo_full;
    assign pop_ok  = cpu_in_rd && !fifo_empty;

    always_comb begin
        in_ovf_d = in_ovf_q;
        if (ovf_evt)     in_ovf_d = 1'b1;
        else if (pop_ok) in_ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ovf_q <= 1'b0;
        else     in_ovf_q <= in_ovf_d;
    end

    assign in_ovf = in_ovf_q;
`else
    assign in_ovf = 1'b0;
`endif

    // ---------------- interrupt FSM ----------------
    // irq is registered and is high exactly while in IRQ_REQ. Ack wins over
    // done and over a simultaneous enable drop; a request is not withdrawn
    // when the FIFO drains, only when irq_en goes low.
    irq_state_t irq_state_q;
    logic       irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_state_q <= IRQ_IDLE;
            irq_q       <= 1'b0;
        end else begin
            case (irq_state_q)
                IRQ_IDLE: begin
                    if (irq_en && !fifo_empty) begin
                        irq_state_q <= IRQ_REQ;
                        irq_q       <= 1'b1;
                    end
                end
                IRQ_REQ: begin
                    if (irq_ack) begin
                        irq_state_q <= IRQ_SERVICE;
                        irq_q       <= 1'b0;
                    end else if (!irq_en) begin
                        irq_state_q <= IRQ_IDLE;
                        irq_q       <= 1'b0;
                    end
                end
                IRQ_SERVICE: begin
                    irq_q <= 1'b0;
                    if (irq_done) irq_state_q <= IRQ_IDLE;
                end
                default: begin
                    irq_state_q <= IRQ_IDLE;
                    irq_q       <= 1'b0;
                end
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_io_port_unit.sv
module tb_io_port_unit;

    localparam int DATA_W   = 16;
    localparam int IN_DEPTH = 4;
    localparam int CNT_W    = 3;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_in_rd;
    logic              cpu_out_wr;
    logic [DATA_W-1:0] cpu_out_data;
    logic [DATA_W-1:0] out_port;
    logic              out_strobe;
    logic              irq_en;
    logic              irq;
    logic              irq_ack;
    logic              irq_done;
    logic [CNT_W-1:0]  in_count;
    logic              in_ovf;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] in_sb[$];   // expected FIFO contents in order
    logic [DATA_W-1:0] out_sb[$];  // expected out_port values in order
    logic              exp_ovf_on_drop;

    io_port_unit #(.DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_in_data  (ext_in_data),
        .ext_in_valid (ext_in_valid),
        .ext_in_ready (ext_in_ready),
        .cpu_in_data  (cpu_in_data),
        .cpu_in_rd    (cpu_in_rd),
        .cpu_out_wr   (cpu_out_wr),
        .cpu_out_data (cpu_out_data),
        .out_port     (out_port),
        .out_strobe   (out_strobe),
        .irq_en       (irq_en),
        .irq          (irq),
        .irq_ack      (irq_ack),
        .irq_done     (irq_done),
        .in_count     (in_count),
        .in_ovf       (in_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one external word for one cycle; record it if it will be taken.
    task automatic push_word(input logic [DATA_W-1:0] w);
        ext_in_data  = w;
        ext_in_valid = 1'b1;
        if (ext_in_ready) in_sb.push_back(w);
        tick();
        ext_in_valid = 1'b0;
    endtask

    // Consume the head word, checking it against the scoreboard.
    task automatic pop_word(input string name);
        logic [DATA_W-1:0] exp;
        exp = (in_sb.size() != 0) ? in_sb.pop_front() : '0;
        checks++;
        if (cpu_in_data !== exp) begin
            errors++;
            $display("FAIL %s: cpu_in_data got %h want %h", name, cpu_in_data, exp);
        end
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (out_port !== '0 || irq !== 1'b0 || in_count !== '0 || ext_in_ready !== 1'b1 ||
            cpu_in_data !== '0 || out_strobe !== 1'b0 || in_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: port=%h irq=%b cnt=%0d rdy=%b data=%h strb=%b ovf=%b want 0/0/0/1/0/0/0",
                     out_port, irq, in_count, ext_in_ready, cpu_in_data, out_strobe, in_ovf);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_count !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL idle: cnt=%0d irq=%b want 0/0", in_count, irq);
        end
    endtask

    task automatic test_fifo_full();
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        push_word(16'h4444);
        checks++;
        if (in_count !== CNT_W'(4) || ext_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: cnt=%0d rdy=%b want 4/0", in_count, ext_in_ready);
        end
        push_word(16'h5555);
        checks++;
        if (in_count !== CNT_W'(4) || in_ovf !== exp_ovf_on_drop) begin
            errors++;
            $display("FAIL drop: cnt=%0d ovf=%b want 4/%b", in_count, in_ovf, exp_ovf_on_drop);
        end
        pop_word("pop1");
        checks++;
        if (in_ovf !== 1'b0 || in_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b cnt=%0d want 0/3", in_ovf, in_count);
        end
        pop_word("pop2");
        pop_word("pop3");
        pop_word("pop4");
        pop_word("pop_empty");
        checks++;
        if (in_count !== '0 || ext_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty: cnt=%0d rdy=%b want 0/1", in_count, ext_in_ready);
        end
    endtask

    task automatic test_push_pop_same();
        logic [DATA_W-1:0] exp;
        push_word(16'hA001);
        exp = in_sb.pop_front();
        checks++;
        if (cpu_in_data !== exp) begin
            errors++;
            $display("FAIL pp_head: cpu_in_data got %h want %h", cpu_in_data, exp);
        end
        ext_in_data  = 16'hA002;
        ext_in_valid = 1'b1;
        cpu_in_rd    = 1'b1;
        in_sb.push_back(16'hA002);
        tick();
        ext_in_valid = 1'b0;
        cpu_in_rd    = 1'b0;
        checks++;
        if (in_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL pp_count: cnt=%0d want 1", in_count);
        end
        pop_word("pp_second");
    endtask

    task automatic test_out_back_to_back();
        logic [DATA_W-1:0] exp;
        int seen;
        seen = 0;
        cpu_out_wr = 1'b1;
        cpu_out_data = 16'hBEEF;
        out_sb.push_back(16'hBEEF);
        tick();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                cpu_out_data = 16'h0001;
                out_sb.push_back(16'h0001);
            end else begin
                cpu_out_wr = 1'b0;
                cpu_out_data = 16'hDEAD;
            end
            checks++;
            if (out_strobe !== 1'b1) begin
                errors++;
                $display("FAIL out_strobe%0d: got %b want 1", i, out_strobe);
            end else begin
                exp = out_sb.pop_front();
                seen++;
                checks++;
                if (out_port !== exp) begin
                    errors++;
                    $display("FAIL out_port%0d: got %h want %h", i, out_port, exp);
                end
            end
            tick();
        end
        checks++;
        if (out_strobe !== 1'b0 || out_port !== 16'h0001 || seen != 2) begin
            errors++;
            $display("FAIL out_hold: strb=%b port=%h seen=%0d want 0/0001/2", out_strobe, out_port, seen);
        end
        out_sb.delete();
    endtask

    task automatic test_irq_basic();
        irq_en = 1'b1;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_no_data: irq=%b want 0", irq);
        end
        push_word(16'h00AA);
        checks++;
        if (irq !== 1'b0 || in_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL irq_lat0: irq=%b cnt=%0d want 0/1", irq, in_count);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: irq=%b want 1", irq);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ack: irq=%b want 0", irq);
        end
        pop_word("irq_pop");
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        repeat (2) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_idle: irq=%b want 0", irq);
        end
    endtask

    task automatic test_irq_rerequest();
        push_word(16'h0B01);
        push_word(16'h0B02);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL rr_rise: irq=%b want 1", irq);
        end
        irq_ack = 1'b1;
        irq_done = 1'b1;   // together in REQ: ack only
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rr_service: irq=%b want 0", irq);
        end
        pop_word("rr_pop");
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap: irq=%b want 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL rr_reassert: irq=%b want 1", irq);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_irq_reset();
        push_word(16'h0C01);
        push_word(16'h0C02);
        checks++;
        if (in_count !== CNT_W'(3) || irq !== 1'b0) begin
            errors++;
            $display("FAIL svc_setup: cnt=%0d irq=%b want 3/0", in_count, irq);
        end
        #2 rst = 1'b1;
        #1;
        in_sb.delete();
        checks++;
        if (irq !== 1'b0 || in_count !== '0 || cpu_in_data !== '0) begin
            errors++;
            $display("FAIL async_rst: irq=%b cnt=%0d data=%h want 0/0/0", irq, in_count, cpu_in_data);
        end
        irq_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        push_word(16'h0F0F);
        checks++;
        if (cpu_in_data !== 16'h0F0F || irq !== 1'b0) begin
            errors++;
            $display("FAIL post_rst: data=%h irq=%b want 0f0f/0", cpu_in_data, irq);
        end
        irq_en = 1'b1;
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL en_req: irq=%b want 1", irq);
        end
        irq_en = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: irq=%b want 0", irq);
        end
        pop_word("post_rst_pop");
    endtask

    initial begin
`ifdef IO_IN_OVERFLOW_EN
        exp_ovf_on_drop = 1'b1;
`else
        exp_ovf_on_drop = 1'b0;
`endif
        rst          = 1'b1;
        ext_in_data  = '0;
        ext_in_valid = 1'b0;
        cpu_in_rd    = 1'b0;
        cpu_out_wr   = 1'b0;
        cpu_out_data = '0;
        irq_en       = 1'b0;
        irq_ack      = 1'b0;
        irq_done     = 1'b0;

        test_reset();
        test_fifo_full();
        test_push_pop_same();
        test_out_back_to_back();
        test_irq_basic();
        test_irq_rerequest();
        test_irq_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
